ram2p: RTL
==========

// Module: ram2p
//
// PURPOSE
//   Parametrised two-port RAM, one write port and one read port, with a registered read.
//   - Byte-lane write masks.
//   - Write-first forwarding when a read and a write hit the same address.
//   - Hardware clear engine: after every reset it writes INIT_VALUE to every word,
//     then raises ready.
//   Used for CPU register files and scratch/data memories that need a known state after reset.
//
// PARAMETERS
//   DWIDTH      32  data width in bits; must be a multiple of 8 (NB = DWIDTH/8 lanes)
//   AWIDTH      8   address width; depth N = 2**AWIDTH words
//   INIT_VALUE  0   DWIDTH-bit value written to every word by the clear engine
//
// PORTS
//   clk      in   1       clock, all state on rising edge
//   reset_n  in   1       asynchronous, active-low reset
//   ready    out  1       1 = clear done, ports accepted
//   we       in   1       write enable
//   waddr    in   AWIDTH  write address
//   wdata    in   DWIDTH  write data
//   wmask    in   NB      per-byte write enable; bit i covers wdata[8i+7:8i]
//   re       in   1       read enable
//   raddr    in   AWIDTH  read address
//   rdata    out  DWIDTH  registered read data
//   rvalid   out  1       rdata updated by the previous edge's read
//
// BEHAVIOUR
//   Reset (reset_n=0, async)
//     - state=CLEAR, clear pointer=0.
//     - Outputs: ready=0, rvalid=0, rdata=0.
//     - Array is not reset directly; the clear engine initialises it.
//   CLEAR
//     - Edge k (k=1..N) after reset release writes INIT_VALUE to word k-1.
//     - After edge N: state=READY, ready=1.
//     - we/re ignored; rvalid=0; rdata=0.
//   READY (ready stays 1 until the next reset)
//     Write
//       - Edge with we=1: every lane i with wmask[i]=1 is written from wdata.
//       - Lanes with wmask[i]=0 keep their old contents.
//       - wmask=0 is a no-op.
//     Read
//       - Edge with re=1: rdata <= R[raddr], rvalid <= 1. Latency 1 cycle.
//       - Edge with re=0: rvalid <= 0, rdata holds its value.
//     Collision (re & we & raddr==waddr, same edge)
//       - rdata returns the merged word: new lanes where wmask=1, old lanes elsewhere.
//       - The array is updated identically.
//   Concurrency and range
//     - Read and write to different addresses proceed independently every cycle.
//     - No stalls; every address is in range (depth is 2**AWIDTH).
//   Reset mid-operation
//     - Any reset_n assertion (during CLEAR or READY) returns to CLEAR with pointer=0.
//     - A full N-cycle clear re-runs; a partial clear is never reported ready.
//
// TESTING
//   1. Reset release, AWIDTH=3, INIT_VALUE=32'hDEAD_BEEF
//      -> ready=0 for edges 1..7, ready=1 after edge 8.
//      -> reading all 8 addresses returns 32'hDEADBEEF, rvalid one cycle after each re.
//   2. Write 32'h11223344 mask 4'b1111 to addr 5, then 32'hAABBCCDD mask 4'b0101 to addr 5,
//      then read addr 5
//      -> rdata=32'h11BB33DD.
//   3. Same edge: we (addr 2, 32'hCAFEF00D, mask 4'b1100) and re (addr 2),
//      where addr 2 holds 32'h00000000
//      -> next cycle rdata=32'hCAFE0000, rvalid=1.
//   4. we/re asserted during CLEAR (addr 0, 32'h12345678)
//      -> rvalid stays 0; after ready, addr 0 reads INIT_VALUE.
//   5. reset_n pulsed low at edge 4 of a CLEAR, and again in READY after writes
//      -> ready drops to 0 immediately (async) and rvalid=0, rdata=0.
//      -> ready returns N edges after release; all words read INIT_VALUE.
//   6. Back-to-back re on addrs 0,1,2, then re=0
//      -> rvalid=1,1,1,0.
//      -> rdata tracks each address one cycle later and holds the last value after re drops.

Source files
------------

// File: rtl/ram2p.sv
// ---------------------------------------------------------------------------
// ram2p -- two-port RAM (one write port, one read port) with registered read
//
// Purpose:
//   Byte-maskable RAM for register files and scratch/data memories. After
//   every reset a clear engine writes INIT_VALUE to every word, one word per
//   clock, and only then raises ready_o. Reads are registered (latency 1).
//   A read and a write to the same address on the same edge return the
//   merged word (write-first forwarding).
//
// Parameters:
//   DWIDTH      data width in bits, multiple of 8 (NB = DWIDTH/8 byte lanes)
//   AWIDTH      address width, depth = 2**AWIDTH words
//   INIT_VALUE  value written to every word by the clear engine
//
// Ports:
//   clk_i      clock, all state on the rising edge
//   reset_ni   asynchronous active-low reset
//   ready_o    1 = clear finished, read/write ports are accepted
//   we_i       write enable
//   waddr_i    write address
//   wdata_i    write data
//   wmask_i    per-byte write enable, bit i covers wdata_i[8i+7:8i]
//   re_i       read enable
//   raddr_i    read address
//   rdata_o    registered read data
//   rvalid_o   rdata_o was updated by the previous edge's read
// ---------------------------------------------------------------------------
module ram2p #(
    parameter int                DWIDTH     = 32,
    parameter int                AWIDTH     = 8,
    parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    output logic                ready_o,
    input  logic                we_i,
    input  logic [AWIDTH-1:0]   waddr_i,
    input  logic [DWIDTH-1:0]   wdata_i,
    input  logic [DWIDTH/8-1:0] wmask_i,
    input  logic                re_i,
    input  logic [AWIDTH-1:0]   raddr_i,
    output logic [DWIDTH-1:0]   rdata_o,
    output logic                rvalid_o
);

    localparam int NB    = DWIDTH / 8;
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   clearPtr_q, clearPtr_d;
    logic [DWIDTH-1:0]   rdata_q;
    logic                rvalid_q;

    logic [DWIDTH-1:0]   mem [DEPTH];

    logic                memWe;
    logic [AWIDTH-1:0]   memAddr;
    logic [DWIDTH-1:0]   memWdata;
    logic [NB-1:0]       memMask;
    logic [DWIDTH-1:0]   readMerged;

    // State and clear pointer registers. The array itself is never reset;
    // the clear engine initialises it word by word.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_CLEAR;
            clearPtr_q <= '0;
        end else begin
            state_q    <= state_d;
            clearPtr_q <= clearPtr_d;
        end
    end

    // Clear sequencing: one word per edge; the edge that writes the last
    // word also moves the FSM to READY, so ready rises exactly DEPTH edges
    // after reset release.
    always_comb begin
        state_d    = state_q;
        clearPtr_d = clearPtr_q;
        case (state_q)
            ST_CLEAR: begin
                clearPtr_d = clearPtr_q + 1'b1;
                if (clearPtr_q == {AWIDTH{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // The single physical write port is shared: the clear engine owns it
    // during CLEAR (user we_i is ignored), the user owns it afterwards.
    always_comb begin
        memWe    = 1'b0;
        memAddr  = waddr_i;
        memWdata = wdata_i;
        memMask  = wmask_i;
        if (state_q == ST_CLEAR) begin
            memWe    = 1'b1;
            memAddr  = clearPtr_q;
            memWdata = INIT_VALUE;
            memMask  = '1;
        end else begin
            memWe    = we_i;
        end
    end

    // Byte-lane masked array write.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            for (int i = 0; i < NB; i++) begin
                if (memMask[i]) begin
                    mem[memAddr][8*i +: 8] <= memWdata[8*i +: 8];
                end
            end
        end
    end

    // Write-first forwarding: on an address match, lanes being written this
    // edge come from wdata_i, the rest from the stored word, so the read
    // returns exactly what the array will hold after the edge.
    always_comb begin
        readMerged = mem[raddr_i];
        if (we_i && (raddr_i == waddr_i)) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask_i[i]) begin
                    readMerged[8*i +: 8] = wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Registered read port. rdata holds when re drops; it is forced to zero
    // while clearing so a partially cleared array is never observed.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else if (state_q == ST_READY) begin
            rvalid_q <= re_i;
            if (re_i) begin
                rdata_q <= readMerged;
            end
        end else begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end
    end

    assign ready_o  = (state_q == ST_READY);
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule
